// File: rtl/hazard_ctrl.sv
// Hazard control for the D/E/M/W pipeline: decodes the instruction in each stage,
// raises Stall for data and mult/div hazards, and drives the operand forwarding selects.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] InstrD,
  input  logic [31:0] InstrE,
  input  logic [31:0] InstrM,
  input  logic [31:0] InstrW,
  output logic        Stall,
  output logic [1:0]  FwdRsD,
  output logic [1:0]  FwdRtD,
  output logic [1:0]  FwdRsE,
  output logic [1:0]  FwdRtE,
  output logic [1:0]  FwdRtM,
  output logic        Busy,
  output logic [31:0] StallCnt
);

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_W  = 2'd1;
  localparam logic [1:0] SEL_M  = 2'd2;
  localparam logic [1:0] SEL_E  = 2'd3;

  typedef struct packed {
    logic       rd_rs;
    logic [1:0] tuse_rs;
    logic       rd_rt;
    logic [1:0] tuse_rt;
    logic [4:0] dst;
    logic [1:0] tnew_e;
    logic [1:0] tnew_m;
    logic       is_md;
    logic       is_mult;
    logic       is_hilo;
  } dec_t;

  // Tnew in W is always 0, so only the E and M values are carried.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rt, input logic [4:0] rd);
    dec_t d;
    d = '0;
    case (op)
      6'h00: begin
        case (fn)
          6'h21, 6'h23: begin
            d.rd_rs   = 1'b1;
            d.tuse_rs = 2'd1;
            d.rd_rt   = 1'b1;
            d.tuse_rt = 2'd1;
            d.dst     = rd;
            d.tnew_e  = 2'd1;
          end
          6'h08: begin
            d.rd_rs   = 1'b1;
            d.tuse_rs = 2'd0;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            d.rd_rs   = 1'b1;
            d.tuse_rs = 2'd1;
            d.rd_rt   = 1'b1;
            d.tuse_rt = 2'd1;
            d.is_md   = 1'b1;
            d.is_mult = (fn == 6'h18) || (fn == 6'h19);
            d.is_hilo = 1'b1;
          end
          6'h10, 6'h12: begin
            d.dst     = rd;
            d.tnew_e  = 2'd1;
            d.is_hilo = 1'b1;
          end
          6'h11, 6'h13: begin
            d.rd_rs   = 1'b1;
            d.tuse_rs = 2'd1;
            d.is_hilo = 1'b1;
          end
          default: ;
        endcase
      end
      6'h0D: begin
        d.rd_rs   = 1'b1;
        d.tuse_rs = 2'd1;
        d.dst     = rt;
        d.tnew_e  = 2'd1;
      end
      6'h0F: begin
        d.dst    = rt;
        d.tnew_e = 2'd1;
      end
      6'h23: begin
        d.rd_rs   = 1'b1;
        d.tuse_rs = 2'd1;
        d.dst     = rt;
        d.tnew_e  = 2'd2;
        d.tnew_m  = 2'd1;
      end
      6'h2B: begin
        d.rd_rs   = 1'b1;
        d.tuse_rs = 2'd1;
        d.rd_rt   = 1'b1;
        d.tuse_rt = 2'd2;
      end
      6'h04: begin
        d.rd_rs   = 1'b1;
        d.tuse_rs = 2'd0;
        d.rd_rt   = 1'b1;
        d.tuse_rt = 2'd0;
      end
      6'h03: d.dst = 5'd31;
      default: ;
    endcase
    return d;
  endfunction

  // The nearest producer of a register is the one that matters; an older one is shadowed.
  function automatic logic src_stall(input logic rd, input logic [1:0] tuse,
                                     input logic [4:0] src, input dec_t e, input dec_t m);
    logic hit;
    hit = 1'b0;
    if (rd && (src != 5'd0)) begin
      if (src == e.dst)      hit = (tuse < e.tnew_e);
      else if (src == m.dst) hit = (tuse < m.tnew_m);
    end
    return hit;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic rd, input logic [4:0] src,
                                         input logic [4:0] dst_e, input logic ok_e,
                                         input logic [4:0] dst_m, input logic ok_m,
                                         input logic [4:0] dst_w);
    logic [1:0] sel;
    sel = SEL_RF;
    if (rd && (src != 5'd0)) begin
      if (ok_e && (src == dst_e))      sel = SEL_E;
      else if (ok_m && (src == dst_m)) sel = SEL_M;
      else if (src == dst_w)           sel = SEL_W;
    end
    return sel;
  endfunction

  dec_t        w_dec_d;
  dec_t        w_dec_e;
  dec_t        w_dec_m;
  dec_t        w_dec_w;
  logic [4:0]  w_rs_d;
  logic [4:0]  w_rt_d;
  logic [4:0]  w_rs_e;
  logic [4:0]  w_rt_e;
  logic [4:0]  w_rt_m;
  logic        w_ok_e;
  logic        w_ok_m;
  logic        w_data_stall;
  logic        w_md_stall;
  logic        w_busy_raw;
  logic        w_stall;
  logic [3:0]  r_md_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_unused;

  assign w_dec_d = decode(InstrD[31:26], InstrD[5:0], InstrD[20:16], InstrD[15:11]);
  assign w_dec_e = decode(InstrE[31:26], InstrE[5:0], InstrE[20:16], InstrE[15:11]);
  assign w_dec_m = decode(InstrM[31:26], InstrM[5:0], InstrM[20:16], InstrM[15:11]);
  assign w_dec_w = decode(InstrW[31:26], InstrW[5:0], InstrW[20:16], InstrW[15:11]);

  assign w_rs_d = InstrD[25:21];
  assign w_rt_d = InstrD[20:16];
  assign w_rs_e = InstrE[25:21];
  assign w_rt_e = InstrE[20:16];
  assign w_rt_m = InstrM[20:16];

  assign w_unused = ^{w_dec_d, w_dec_e, w_dec_m, w_dec_w,
                      InstrD[10:6], InstrE[10:6], InstrM[25:21], InstrM[10:6],
                      InstrW[25:21], InstrW[10:6]};

  assign w_ok_e = (w_dec_e.tnew_e == 2'd0);
  assign w_ok_m = (w_dec_m.tnew_m == 2'd0);

  assign w_data_stall = src_stall(w_dec_d.rd_rs, w_dec_d.tuse_rs, w_rs_d, w_dec_e, w_dec_m) |
                        src_stall(w_dec_d.rd_rt, w_dec_d.tuse_rt, w_rt_d, w_dec_e, w_dec_m);

  assign w_busy_raw = (r_md_cnt != 4'd0) | w_dec_e.is_md;
  assign w_md_stall = w_dec_d.is_hilo & w_busy_raw;
  assign w_stall    = Rst_n & (w_data_stall | w_md_stall);

  assign Stall    = w_stall;
  assign Busy     = Rst_n & w_busy_raw;
  assign StallCnt = r_stall_cnt;

  // All selects are forced to the regfile/own copy while reset is held.
  always_comb begin
    FwdRsD = SEL_RF;
    FwdRtD = SEL_RF;
    FwdRsE = SEL_RF;
    FwdRtE = SEL_RF;
    FwdRtM = SEL_RF;
    if (Rst_n) begin
      FwdRsD = fwd_sel(w_dec_d.rd_rs, w_rs_d, w_dec_e.dst, w_ok_e,
                       w_dec_m.dst, w_ok_m, w_dec_w.dst);
      FwdRtD = fwd_sel(w_dec_d.rd_rt, w_rt_d, w_dec_e.dst, w_ok_e,
                       w_dec_m.dst, w_ok_m, w_dec_w.dst);
      FwdRsE = fwd_sel(w_dec_e.rd_rs, w_rs_e, 5'd0, 1'b0,
                       w_dec_m.dst, w_ok_m, w_dec_w.dst);
      FwdRtE = fwd_sel(w_dec_e.rd_rt, w_rt_e, 5'd0, 1'b0,
                       w_dec_m.dst, w_ok_m, w_dec_w.dst);
      FwdRtM = fwd_sel(w_dec_m.rd_rt, w_rt_m, 5'd0, 1'b0,
                       5'd0, 1'b0, w_dec_w.dst);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_md_cnt <= 4'd0;
    end else if (w_dec_e.is_md && w_dec_e.is_mult) begin
      r_md_cnt <= 4'(MULT_CYCLES);
    end else if (w_dec_e.is_md) begin
      r_md_cnt <= 4'(DIV_CYCLES);
    end else if (r_md_cnt != 4'd0) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stall, forwarding, mult/div busy and reset scenarios.
module tb_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] InstrD, InstrE, InstrM, InstrW;
  logic        Stall;
  logic [1:0]  FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM;
  logic        Busy;
  logic [31:0] StallCnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .InstrD   (InstrD),
    .InstrE   (InstrE),
    .InstrM   (InstrM),
    .InstrW   (InstrW),
    .Stall    (Stall),
    .FwdRsD   (FwdRsD),
    .FwdRtD   (FwdRtD),
    .FwdRsE   (FwdRsE),
    .FwdRtE   (FwdRtE),
    .FwdRtM   (FwdRtM),
    .Busy     (Busy),
    .StallCnt (StallCnt)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  function automatic logic [31:0] ADDU(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt);
    return r_op(rs, rt, rd, 6'h21);
  endfunction

  function automatic logic [31:0] LW(input logic [4:0] rt, input logic [4:0] base);
    return i_op(6'h23, base, rt);
  endfunction

  function automatic logic [31:0] SW(input logic [4:0] rt, input logic [4:0] base);
    return i_op(6'h2B, base, rt);
  endfunction

  function automatic logic [31:0] BEQ(input logic [4:0] rs, input logic [4:0] rt);
    return i_op(6'h04, rs, rt);
  endfunction

  function automatic logic [31:0] JR(input logic [4:0] rs);
    return r_op(rs, 5'd0, 5'd0, 6'h08);
  endfunction

  function automatic logic [31:0] MULT(input logic [4:0] rs, input logic [4:0] rt);
    return r_op(rs, rt, 5'd0, 6'h18);
  endfunction

  function automatic logic [31:0] DIV(input logic [4:0] rs, input logic [4:0] rt);
    return r_op(rs, rt, 5'd0, 6'h1A);
  endfunction

  function automatic logic [31:0] MFHI(input logic [4:0] rd);
    return r_op(5'd0, 5'd0, rd, 6'h10);
  endfunction

  localparam logic [31:0] JAL = {6'h03, 26'h0000040};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [31:0] d, input logic [31:0] e,
                           input logic [31:0] m, input logic [31:0] w);
    InstrD = d;
    InstrE = e;
    InstrM = m;
    InstrW = w;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held: outputs gated even with hazards on the inputs
    Rst_n = 1'b0;
    set_instr(MFHI(5'd9), MULT(5'd1, 5'd2), 32'h0, 32'h0);
    #2;
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_stallcnt", StallCnt, 32'd0);
    tick();
    chk("rst_busy_after_edge", {31'd0, Busy}, 32'd0);
    set_instr(JR(5'd31), JAL, 32'h0, 32'h0);
    #1;
    chk("rst_fwd", {22'd0, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM}, 32'd0);
    set_instr(32'h0, 32'h0, 32'h0, 32'h0);
    #1 Rst_n = 1'b1;
    #1;
    chk("rel_busy", {31'd0, Busy}, 32'd0);
    chk("rel_stallcnt", StallCnt, 32'd0);

    // Load-use
    tick();
    set_instr(ADDU(5'd2, 5'd1, 5'd1), LW(5'd1, 5'd0), 32'h0, 32'h0);
    #1;
    chk("lu_stall", {31'd0, Stall}, 32'd1);
    tick();
    set_instr(32'h0, ADDU(5'd2, 5'd1, 5'd1), 32'h0, LW(5'd1, 5'd0));
    #1;
    chk("lu_stall_next", {31'd0, Stall}, 32'd0);
    chk("lu_fwdrse", {30'd0, FwdRsE}, 32'd1);
    chk("lu_fwdrte", {30'd0, FwdRtE}, 32'd1);
    chk("lu_stallcnt", StallCnt, 32'd1);

    // ALU result to branch
    tick();
    set_instr(BEQ(5'd3, 5'd0), ADDU(5'd3, 5'd1, 5'd2), 32'h0, 32'h0);
    #1;
    chk("ab_stall", {31'd0, Stall}, 32'd1);
    chk("ab_fwdrsd_early", {30'd0, FwdRsD}, 32'd0);
    tick();
    set_instr(BEQ(5'd3, 5'd0), 32'h0, ADDU(5'd3, 5'd1, 5'd2), 32'h0);
    #1;
    chk("ab_stall_next", {31'd0, Stall}, 32'd0);
    chk("ab_fwdrsd", {30'd0, FwdRsD}, 32'd2);
    chk("ab_fwdrtd", {30'd0, FwdRtD}, 32'd0);
    chk("ab_stallcnt", StallCnt, 32'd2);

    // jal to jr, and priority between stages
    tick();
    set_instr(JR(5'd31), JAL, 32'h0, 32'h0);
    #1;
    chk("jj_stall", {31'd0, Stall}, 32'd0);
    chk("jj_fwdrsd", {30'd0, FwdRsD}, 32'd3);
    set_instr(JR(5'd31), JAL, ADDU(5'd31, 5'd1, 5'd2), LW(5'd31, 5'd0));
    #1;
    chk("prio_e_first", {30'd0, FwdRsD}, 32'd3);
    set_instr(JR(5'd31), 32'h0, ADDU(5'd31, 5'd1, 5'd2), LW(5'd31, 5'd0));
    #1;
    chk("prio_m_over_w", {30'd0, FwdRsD}, 32'd2);
    set_instr(JR(5'd31), 32'h0, 32'h0, LW(5'd31, 5'd0));
    #1;
    chk("prio_w_only", {30'd0, FwdRsD}, 32'd1);

    // E and M stage forwarding, $0 destination
    tick();
    set_instr(32'h0, ADDU(5'd7, 5'd6, 5'd8), ADDU(5'd6, 5'd1, 5'd1), ADDU(5'd8, 5'd1, 5'd1));
    #1;
    chk("e_fwdrse", {30'd0, FwdRsE}, 32'd2);
    chk("e_fwdrte", {30'd0, FwdRtE}, 32'd1);
    set_instr(32'h0, 32'h0, SW(5'd5, 5'd0), ADDU(5'd5, 5'd1, 5'd1));
    #1;
    chk("m_fwdrtm", {30'd0, FwdRtM}, 32'd1);
    set_instr(ADDU(5'd4, 5'd0, 5'd0), LW(5'd0, 5'd0), ADDU(5'd0, 5'd1, 5'd1), LW(5'd0, 5'd0));
    #1;
    chk("zero_stall", {31'd0, Stall}, 32'd0);
    chk("zero_fwd", {22'd0, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM}, 32'd0);

    // lw in M feeding a branch, then a reset pulse clears the count
    tick();
    set_instr(BEQ(5'd3, 5'd0), 32'h0, LW(5'd3, 5'd0), 32'h0);
    #1;
    chk("lwm_stall", {31'd0, Stall}, 32'd1);
    set_instr(32'h0, 32'h0, 32'h0, 32'h0);
    Rst_n = 1'b0;
    #1;
    chk("pulse_stallcnt", StallCnt, 32'd0);
    Rst_n = 1'b1;
    #1;

    // Mult busy with mfhi waiting in D
    tick();
    set_instr(MFHI(5'd9), MULT(5'd1, 5'd2), 32'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("mult_stall_%0d", k), {31'd0, Stall}, 32'd1);
      chk($sformatf("mult_busy_%0d", k), {31'd0, Busy}, 32'd1);
      tick();
      InstrE = 32'h0;
    end
    #1;
    chk("mult_stall_end", {31'd0, Stall}, 32'd0);
    chk("mult_busy_end", {31'd0, Busy}, 32'd0);
    chk("mult_stallcnt", StallCnt, 32'd6);

    // Reset in the middle of a div countdown
    tick();
    set_instr(32'h0, DIV(5'd1, 5'd2), 32'h0, 32'h0);
    #1;
    chk("div_busy_e", {31'd0, Busy}, 32'd1);
    tick();
    InstrE = 32'h0;
    repeat (3) tick();
    chk("div_busy_cnt7", {31'd0, Busy}, 32'd1);
    #1;
    Rst_n  = 1'b0;
    InstrD = MFHI(5'd9);
    #1;
    chk("div_rst_busy", {31'd0, Busy}, 32'd0);
    chk("div_rst_stallcnt", StallCnt, 32'd0);
    chk("div_rst_stall", {31'd0, Stall}, 32'd0);
    tick();
    tick();
    chk("div_rst_busy_held", {31'd0, Busy}, 32'd0);
    #1 Rst_n = 1'b1;
    #1;
    chk("div_rel_stall", {31'd0, Stall}, 32'd0);
    chk("div_rel_busy", {31'd0, Busy}, 32'd0);
    tick();
    chk("div_rel_stall_next", {31'd0, Stall}, 32'd0);
    chk("div_rel_stallcnt", StallCnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
